uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART RX top.
- Captures each completed byte from the RX top (p_data qualified by data_valid) into a DEPTH-entry circular FIFO.
- Exposes a registered-read handshake to the host side, plus full, empty and occupancy status.
- Keeps a sticky overrun flag and saturating counters of parity and stop errors, so that framing problems are visible even though the RX top never writes erroneous frames.

Parameters:
DATA_WIDTH, 8, width of stored byte (matches p_data)
DEPTH, 16, number of FIFO entries; power of two, 2..256
ADDR_WIDTH, 4, log2(DEPTH); pointer width
ERR_CNT_WIDTH, 8, width of each saturating error counter

Ports:
clk  input  1  system clock, same clock as the RX top
rst  input  1  asynchronous active-low reset
p_data  input  DATA_WIDTH  parallel byte from RX top
data_valid  input  1  RX top frame-good indication (may be held more than one cycle)
parity_error  input  1  RX top parity error indication
stop_error  input  1  RX top stop error indication
rd_en  input  1  host read request
err_clr  input  1  synchronous clear of overrun and both error counters
rd_data  output  DATA_WIDTH  read byte, registered
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
empty  output  1  FIFO holds zero entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full
par_err_cnt  output  ERR_CNT_WIDTH  parity-error frames seen, saturating
stop_err_cnt  output  ERR_CNT_WIDTH  stop-error frames seen, saturating

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count clear to 0; empty=1, full=0.
  - rd_data=0, rd_valid=0, overrun=0, both counters=0.
  - Edge-detect registers for data_valid, parity_error and stop_error clear to 0.
  - Memory contents are don't-care.
- Write event:
  - wr_evt = data_valid & ~data_valid_q, where data_valid_q is data_valid registered.
  - Exactly one write occurs per frame, however long data_valid is held.
  - p_data is sampled in the same cycle as wr_evt.
- Read event: rd_evt = rd_en & ~empty.
  - rd_en while empty is ignored: no pointer move, no rd_valid.
- Read latency is 1 cycle.
  - rd_evt in cycle N: rd_data = mem[rd_ptr] and rd_valid=1 in cycle N+1.
  - Otherwise rd_valid=0 and rd_data holds its last value.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count is the authoritative occupancy; empty = (count==0), full = (count==DEPTH).
- Simultaneous events (all decided on pre-cycle state):
  - wr_evt & rd_evt, not full: both happen, count unchanged.
  - wr_evt & rd_evt while full: the read frees a slot, the write is accepted, count stays DEPTH, no overrun.
  - wr_evt & rd_en while empty: the write happens, the read is ignored; the byte becomes readable next cycle. There is no write-to-read bypass.
  - wr_evt while full without rd_evt: byte dropped, pointers unchanged, overrun set to 1.
- overrun stays 1 until err_clr. If err_clr and a new overrun occur in the same cycle, the set wins.
- Error counters:
  - par_err_cnt increments on the rising edge of parity_error; stop_err_cnt increments on the rising edge of stop_error.
  - Both may increment in the same cycle.
  - Each saturates at all-ones (no wrap).
  - err_clr zeroes the counter; a same-cycle increment is applied after the clear (result 1).
- Error frames never write to the FIFO.
- Reset asserted mid-operation discards all stored data immediately.

Test Plan:
- Reset, then pulse data_valid for 1 cycle with p_data=0xA5, then rd_en for 1 cycle -> count 0→1→0; rd_valid pulses 1 cycle later with rd_data=0xA5; empty returns to 1.
- Hold data_valid high for 5 cycles with p_data=0x3C -> exactly one entry written, count=1.
- Write 16 bytes 0x00..0x0F, then a 17th (0xFF) -> full=1, count=16, overrun=1. Reading 16 bytes returns 0x00..0x0F in order and 0xFF is absent. err_clr then clears overrun.
- With FIFO full, assert wr_evt (0x77) and rd_en together -> rd_data=0x00, count stays 16, overrun stays 0, 0x77 read last. Then write/read 40 bytes continuously to exercise pointer wrap -> data order preserved.
- With FIFO empty, assert wr_evt (0x11) and rd_en together -> no rd_valid that cycle+1, count=1; a following rd_en returns 0x11.
- Pulse parity_error 3 times and stop_error 300 times -> par_err_cnt=3, stop_err_cnt=255 (saturated), FIFO count unchanged. err_clr with a coincident parity_error edge -> par_err_cnt=1, stop_err_cnt=0. Assert rst low mid-test -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART RX top / host and the receive FIFO.
// The RX-side inputs (p_data, qualifiers) and the host-side read and status
// signals share one interface so the FIFO is wired with a single port.
// master: the side that feeds bytes and reads them back (RX top + host).
// slave : the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
);

    // RX-top side
    logic [DATA_WIDTH-1:0]    p_data;
    logic                     data_valid;
    logic                     parity_error;
    logic                     stop_error;

    // Host side: requests
    logic                     rd_en;
    logic                     err_clr;

    // Host side: read data and status
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_valid;
    logic                     empty;
    logic                     full;
    logic [ADDR_WIDTH:0]      count;
    logic                     overrun;
    logic [ERR_CNT_WIDTH-1:0] par_err_cnt;
    logic [ERR_CNT_WIDTH-1:0] stop_err_cnt;

    modport master (
        output p_data,
        output data_valid,
        output parity_error,
        output stop_error,
        output rd_en,
        output err_clr,
        input  rd_data,
        input  rd_valid,
        input  empty,
        input  full,
        input  count,
        input  overrun,
        input  par_err_cnt,
        input  stop_err_cnt
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  parity_error,
        input  stop_error,
        input  rd_en,
        input  err_clr,
        output rd_data,
        output rd_valid,
        output empty,
        output full,
        output count,
        output overrun,
        output par_err_cnt,
        output stop_err_cnt
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO sitting directly behind the UART RX top.
// - One write per good frame: the rising edge of data_valid captures p_data,
//   no matter how long data_valid stays high.
// - Registered read: rd_en on a non-empty FIFO presents the head byte on
//   rd_data one cycle later together with a single-cycle rd_valid.
// - count is the single source of truth for occupancy; empty/full derive
//   from it, which removes the classic "pointers equal: full or empty?"
//   ambiguity.
// - Sticky overrun plus saturating parity/stop error counters make framing
//   problems visible, since the RX top never hands over a bad frame.
module uart_rx_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,     // asynchronous, active low
    uart_rx_fifo_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]      FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX    = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0]    wr_ptr;
    logic [ADDR_WIDTH-1:0]    rd_ptr;
    logic [ADDR_WIDTH:0]      count_q;

    logic                     data_valid_q;
    logic                     parity_error_q;
    logic                     stop_error_q;

    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic                     rd_valid_q;
    logic                     overrun_q;
    logic [ERR_CNT_WIDTH-1:0] par_err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0] stop_err_cnt_q;

    // ------------------------------------------------------------------
    // Event decode, all from pre-cycle state
    // ------------------------------------------------------------------
    logic empty_w;
    logic full_w;
    logic wr_evt;     // new frame presented by the RX top
    logic rd_evt;     // host read that actually pops an entry
    logic wr_ok;      // frame is stored
    logic wr_drop;    // frame is lost because there is no room
    logic par_edge;
    logic stop_edge;

    assign empty_w   = (count_q == '0);
    assign full_w    = (count_q == FULL_COUNT);

    assign wr_evt    = bus.data_valid & ~data_valid_q;
    assign rd_evt    = bus.rd_en & ~empty_w;

    // A read in the same cycle frees the slot the write needs, so a full
    // FIFO still accepts the byte when it is being read at the same time.
    assign wr_ok     = wr_evt & (~full_w | rd_evt);
    assign wr_drop   = wr_evt & full_w & ~rd_evt;

    assign par_edge  = bus.parity_error & ~parity_error_q;
    assign stop_edge = bus.stop_error & ~stop_error_q;

    // ------------------------------------------------------------------
    // Edge-detect registers for the RX-top qualifiers
    // ------------------------------------------------------------------
    // Delay the level inputs by one cycle so rising edges can be found.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst) begin
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            data_valid_q   <= bus.data_valid;
            parity_error_q <= bus.parity_error;
            stop_error_q   <= bus.stop_error;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Store an accepted byte at the write pointer.
    // NOTE: the array has no reset on purpose; its contents are don't-care
    // after reset because count gates every read, and a reset here would
    // stop the array from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.p_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // Advance pointers on accepted events; they wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_evt) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Track occupancy; a simultaneous write and read leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (wr_ok && !rd_evt) begin
            count_q <= count_q + (ADDR_WIDTH+1)'(1);
        end else if (!wr_ok && rd_evt) begin
            count_q <= count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    // Present the head entry one cycle after a read; hold it otherwise.
    // When full and written in the same cycle, wr_ptr equals rd_ptr, and
    // the read still sees the old entry because the array updates at the
    // same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_evt;
            if (rd_evt) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
    // Sticky overrun: a dropped byte sets it, err_clr clears it, set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (wr_drop) begin
            overrun_q <= 1'b1;
        end else if (bus.err_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Saturating parity-error counter; an edge coinciding with err_clr
    // is counted after the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            par_err_cnt_q <= ERR_CNT_WIDTH'(par_edge);
        end else if (par_edge && par_err_cnt_q != CNT_MAX) begin
            par_err_cnt_q <= par_err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Saturating stop-error counter, same rules as the parity counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            stop_err_cnt_q <= ERR_CNT_WIDTH'(stop_edge);
        end else if (stop_edge && stop_err_cnt_q != CNT_MAX) begin
            stop_err_cnt_q <= stop_err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = count_q;
    assign bus.overrun      = overrun_q;
    assign bus.par_err_cnt  = par_err_cnt_q;
    assign bus.stop_err_cnt = stop_err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int EW    = 8;
    localparam int CMAX  = (1 << EW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW)) bus ();

    uart_rx_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (AW),
        .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bench copies of the inputs currently applied
    logic          in_dv, in_pe, in_se, in_rd, in_clr;
    logic [DW-1:0] in_data;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_overrun;
    int            m_par;
    int            m_stop;
    logic          m_dv_prev, m_pe_prev, m_se_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_overrun  = 1'b0;
        m_par      = 0;
        m_stop     = 0;
        m_dv_prev  = 1'b0;
        m_pe_prev  = 1'b0;
        m_se_prev  = 1'b0;
    endtask

    // One clock of the behavioural model, applied to the inputs at the edge.
    task automatic model_step();
        bit wr, rd, dropped, pe_edge, se_edge;
        wr      = in_dv && !m_dv_prev;
        rd      = in_rd && (m_q.size() != 0);
        pe_edge = in_pe && !m_pe_prev;
        se_edge = in_se && !m_se_prev;
        dropped = 1'b0;
        m_rd_valid = rd;
        if (rd) m_rd_data = m_q.pop_front();
        if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back(in_data);
            else dropped = 1'b1;
        end
        if (dropped)     m_overrun = 1'b1;
        else if (in_clr) m_overrun = 1'b0;
        if (in_clr) begin
            m_par  = pe_edge ? 1 : 0;
            m_stop = se_edge ? 1 : 0;
        end else begin
            if (pe_edge && m_par < CMAX)  m_par++;
            if (se_edge && m_stop < CMAX) m_stop++;
        end
        m_dv_prev = in_dv;
        m_pe_prev = in_pe;
        m_se_prev = in_se;
    endtask

    task automatic check_all();
        check("rd_valid", bus.rd_valid, m_rd_valid);
        check("rd_data", bus.rd_data, m_rd_data);
        check("count", bus.count, m_q.size());
        check("empty", bus.empty, m_q.size() == 0);
        check("full", bus.full, m_q.size() == DEPTH);
        check("overrun", bus.overrun, m_overrun);
        check("par_err_cnt", bus.par_err_cnt, m_par);
        check("stop_err_cnt", bus.stop_err_cnt, m_stop);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_par"}, bus.par_err_cnt, 0);
        check({tag, "_stop"}, bus.stop_err_cnt, 0);
    endtask

    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pe,
                         input logic se, input logic rd, input logic clr);
        in_dv = dv; in_data = d; in_pe = pe; in_se = se; in_rd = rd; in_clr = clr;
        bus.data_valid   = dv;
        bus.p_data       = d;
        bus.parity_error = pe;
        bus.stop_error   = se;
        bus.rd_en        = rd;
        bus.err_clr      = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        idle();
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        check_reset_values("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single byte round trip
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t1_count1", bus.count, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t1_rd_valid", bus.rd_valid, 1);
        check("t1_rd_data", bus.rd_data, 8'hA5);
        check("t1_count0", bus.count, 0);
        idle();
        tick();
        check("t1_rd_valid_low", bus.rd_valid, 0);
        check("t1_empty", bus.empty, 1);

        // data_valid held for five cycles stores one byte
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        check("t2_count", bus.count, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t2_rd_data", bus.rd_data, 8'h3C);
        idle();
        tick();

        // Fill, overflow, drain in order, clear overrun
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        write_byte(8'hFF);
        check("t3_full", bus.full, 1);
        check("t3_count", bus.count, DEPTH);
        check("t3_overrun", bus.overrun, 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            check("t3_order", bus.rd_data, i);
        end
        idle();
        tick();
        check("t3_empty", bus.empty, 1);
        check("t3_overrun_sticky", bus.overrun, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("t3_overrun_clr", bus.overrun, 0);

        // Simultaneous write and read while full, then pointer wrap
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t4_rd_data", bus.rd_data, 8'h00);
        check("t4_count", bus.count, DEPTH);
        check("t4_overrun", bus.overrun, 0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (i == 15) check("t4_77_last", bus.rd_data, 8'h77);
        end
        check("t4_wrap_count", bus.count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        check("t4_last", bus.rd_data, 8'hA7);
        idle();
        tick();

        // Write and read together while empty: no bypass
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t5_no_rd_valid", bus.rd_valid, 0);
        check("t5_count", bus.count, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t5_rd_valid", bus.rd_valid, 1);
        check("t5_rd_data", bus.rd_data, 8'h11);
        idle();
        tick();

        // Error counters and saturation
        write_byte(8'h42);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            idle();
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            idle();
            tick();
        end
        check("t6_par", bus.par_err_cnt, 3);
        check("t6_stop_sat", bus.stop_err_cnt, 255);
        check("t6_count", bus.count, 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("t6_par_clr", bus.par_err_cnt, 1);
        check("t6_stop_clr", bus.stop_err_cnt, 0);
        idle();
        tick();

        // Randomized traffic, alternating read-light and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = ((i / 300) % 2 == 1) ? 80 : 15;
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 63) == 0));
            tick();
            if (i == 1700) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
